dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory between the core's load/store path (port C) and a DMA/program-loader master (port D). It sits between the datapath/controller and the data memory, drives the memory's address, write-data, mask, write/read enables and chip select, and returns registered read data to whichever port was granted. Ties are resolved round-robin. DMA may lock the memory for a bounded burst. The core sees a stall whenever its request is not granted.

## Interface
Parameters:
- AW, 32, address width.
- DW, 32, data width (mask width is DW/8).
- MAX_BURST, 4, maximum consecutive locked DMA grants while the core is waiting (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- c_req  in  1  core access request (load or store this cycle).
- c_we  in  1  1 = store, 0 = load.
- c_addr  in  AW  core byte address.
- c_wdata  in  DW  core store data.
- c_mask  in  DW/8  core byte-lane mask.
- c_gnt  out  1  core access performed this cycle.
- c_stall  out  1  c_req & ~c_gnt; freezes core PC/pipeline.
- c_rvalid  out  1  core load data valid (cycle after load grant).
- d_req, d_we, d_addr, d_wdata, d_mask  in  1/1/AW/DW/DW/8  DMA equivalents.
- d_lock  in  1  DMA requests burst lock.
- d_gnt  out  1  DMA access performed this cycle.
- d_rvalid  out  1  DMA load data valid.
- rdata  out  DW  registered load data (shared; qualified by c_rvalid/d_rvalid).
- mem_addr, mem_wdata, mem_mask  out  AW/DW/DW/8  to data memory.
- mem_wr_en, mem_rd_en, mem_cs  out  1  memory write enable, read enable, chip select (active high).
- mem_rdata  in  DW  memory read data, valid combinationally in the grant cycle.

## Operation
- State: last_gnt (0=C, 1=D), burst_cnt (0..MAX_BURST), rdata register, rvalid_c, rvalid_d flags.
- Grant decision (combinational, same cycle as request):
  - rst high: no grant.
  - Only one req: grant it.
  - Both req, lock active (last_gnt=D, d_lock=1, burst_cnt<MAX_BURST): grant D.
  - Both req, otherwise: grant port ≠ last_gnt.
- At most one grant per cycle; c_gnt & d_gnt never both 1.
- Memory mux: granted port's addr/wdata/mask to mem_*; mem_cs = any grant; mem_wr_en = grant & we; mem_rd_en = grant & ~we. No grant: mem_addr/wdata/mask = 0, enables 0.
- On clock edge:
  - Any grant: last_gnt ← granted port.
  - burst_cnt: D granted with d_lock=1 and c_req=1 → +1 (saturates at MAX_BURST); C granted, d_lock=0, or no D grant → 0.
  - Load granted: rdata ← mem_rdata; rvalid of that port ← 1, other ← 0. No load grant: both rvalid ← 0, rdata holds.
- Store grants never raise rvalid.

## Timing
- Reset values (after rst edge): last_gnt=1 (so core wins first tie), burst_cnt=0, rdata=0, c_rvalid=d_rvalid=0. While rst=1: c_gnt=d_gnt=0, all mem enables 0, c_stall=c_req.
- Grant and memory strobe: 0-cycle latency from request. Store committed at the grant-cycle clock edge.
- Load data: rvalid/rdata 1 cycle after grant, valid for exactly 1 cycle.
- A requester holds req and all qualifiers stable until it sees gnt high; dropping req before gnt is allowed and cancels the access.
- Back-to-back contention with no lock: grants alternate C,D,C,D…
- Locked DMA with core waiting: at most MAX_BURST consecutive D grants, then the core is guaranteed the next grant. Core waits at most MAX_BURST+1 cycles.
- Lock with core idle: D granted every cycle; burst_cnt stays 0.
- Reset asserted mid-burst or with a pending load: state cleared at that edge; a load granted in the reset-assert cycle produces no rvalid.

## Test plan
- Reset: hold rst 2 cycles with c_req=d_req=1 → both gnt 0, mem_cs 0, c_stall 1. After release, first contention cycle grants C.
- Single core: core store addr 0x10 data 0xDEADBEEF mask 0xF, then load 0x10 → c_gnt each cycle, c_rvalid 1 cycle after load with rdata 0xDEADBEEF, d_rvalid 0.
- Round-robin: both request loads continuously, no lock → grants C,D,C,D over 4 cycles. rvalid alternates correspondingly, c_stall=1 on D cycles.
- Burst lock: MAX_BURST=4, d_lock=1, c_req=1 throughout, DMA granted first → D,D,D,D,C,D…, burst_cnt reaches 4 then clears.
- Lock with core idle: d_lock=1 for 10 cycles, c_req=0 → 10 consecutive d_gnt. Core request in cycle 11 is granted within ≤5 cycles.
- Reset mid-access: DMA load granted while rst rises the same cycle → d_rvalid stays 0 next cycle, rdata=0, last_gnt=1.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core/DMA requesters, the arbiter and the data memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // core load/store port
  logic            c_req;
  logic            c_we;
  logic [AW-1:0]   c_addr;
  logic [DW-1:0]   c_wdata;
  logic [DW/8-1:0] c_mask;
  logic            c_gnt;
  logic            c_stall;
  logic            c_rvalid;

  // DMA / program-loader port
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_mask;
  logic            d_lock;
  logic            d_gnt;
  logic            d_rvalid;

  // shared read data and data-memory side
  logic [DW-1:0]   rdata;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_mask;
  logic            mem_wr_en;
  logic            mem_rd_en;
  logic            mem_cs;
  logic [DW-1:0]   mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_mask,
    output c_gnt, c_stall, c_rvalid,
    input  d_req, d_we, d_addr, d_wdata, d_mask, d_lock,
    output d_gnt, d_rvalid,
    output rdata,
    output mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en, mem_cs,
    input  mem_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_mask,
    input  c_gnt, c_stall, c_rvalid,
    output d_req, d_we, d_addr, d_wdata, d_mask, d_lock,
    input  d_gnt, d_rvalid,
    input  rdata,
    input  mem_addr, mem_wdata, mem_mask, mem_wr_en, mem_rd_en, mem_cs,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core (C) and a DMA master (D): round-robin
// on ties, bounded DMA burst lock, zero-latency grant, registered load data.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus
);

  localparam int                CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]     MAX_CNT = CW'(MAX_BURST);

  typedef enum logic {
    PORT_C = 1'b0,
    PORT_D = 1'b1
  } port_e;

  port_e           r_last_gnt, w_last_gnt_next;
  logic [CW-1:0]   r_burst_cnt, w_burst_cnt_next;
  logic [DW-1:0]   r_rdata, w_rdata_next;
  logic            r_c_rvalid, w_c_rvalid_next;
  logic            r_d_rvalid, w_d_rvalid_next;

  logic            w_c_gnt;
  logic            w_d_gnt;
  logic            w_lock;
  logic            w_load;

  // DMA keeps the memory only while it owns it, asks for lock and has budget left.
  assign w_lock = (r_last_gnt == PORT_D) && bus.d_lock && (r_burst_cnt < MAX_CNT);

  always_comb begin
    w_c_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (!rst) begin
      if (bus.c_req && !bus.d_req) begin
        w_c_gnt = 1'b1;
      end else if (!bus.c_req && bus.d_req) begin
        w_d_gnt = 1'b1;
      end else if (bus.c_req && bus.d_req) begin
        if (w_lock || (r_last_gnt == PORT_C)) begin
          w_d_gnt = 1'b1;
        end else begin
          w_c_gnt = 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_mask  = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_rd_en = 1'b0;
    if (w_c_gnt) begin
      bus.mem_addr  = bus.c_addr;
      bus.mem_wdata = bus.c_wdata;
      bus.mem_mask  = bus.c_mask;
      bus.mem_wr_en = bus.c_we;
      bus.mem_rd_en = ~bus.c_we;
    end else if (w_d_gnt) begin
      bus.mem_addr  = bus.d_addr;
      bus.mem_wdata = bus.d_wdata;
      bus.mem_mask  = bus.d_mask;
      bus.mem_wr_en = bus.d_we;
      bus.mem_rd_en = ~bus.d_we;
    end
  end

  assign bus.mem_cs   = w_c_gnt | w_d_gnt;
  assign w_load       = bus.mem_rd_en;
  assign bus.c_gnt    = w_c_gnt;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.c_stall  = bus.c_req & ~w_c_gnt;
  assign bus.c_rvalid = r_c_rvalid;
  assign bus.d_rvalid = r_d_rvalid;
  assign bus.rdata    = r_rdata;

  always_comb begin
    w_last_gnt_next  = r_last_gnt;
    w_burst_cnt_next = '0;
    w_rdata_next     = r_rdata;
    w_c_rvalid_next  = w_c_gnt & ~bus.c_we;
    w_d_rvalid_next  = w_d_gnt & ~bus.d_we;

    if (w_c_gnt) begin
      w_last_gnt_next = PORT_C;
    end else if (w_d_gnt) begin
      w_last_gnt_next = PORT_D;
    end

    // Only a locked grant that actually blocked the core counts toward the burst.
    if (w_d_gnt && bus.d_lock && bus.c_req) begin
      w_burst_cnt_next = (r_burst_cnt < MAX_CNT) ? r_burst_cnt + 1'b1 : r_burst_cnt;
    end

    if (w_load) begin
      w_rdata_next = bus.mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_gnt  <= PORT_D;
      r_burst_cnt <= '0;
      r_rdata     <= '0;
      r_c_rvalid  <= 1'b0;
      r_d_rvalid  <= 1'b0;
    end else begin
      r_last_gnt  <= w_last_gnt_next;
      r_burst_cnt <= w_burst_cnt_next;
      r_rdata     <= w_rdata_next;
      r_c_rvalid  <= w_c_rvalid_next;
      r_d_rvalid  <= w_d_rvalid_next;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-masked memory model.
// Word i of the model starts out as 32'hA000_0000 + i.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

  dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_mask[b]) mem[bus.mem_addr[9:2]][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_mask = 4'hF;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_mask = 4'hF;
    bus.d_lock = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.c_req = 1'b1; bus.c_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_addr = 32'h80;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks += 4;
      if (bus.c_gnt !== 1'b0)   begin n_fail++; $display("FAIL rst_c_gnt: got %b expected 0", bus.c_gnt); end
      if (bus.d_gnt !== 1'b0)   begin n_fail++; $display("FAIL rst_d_gnt: got %b expected 0", bus.d_gnt); end
      if (bus.mem_cs !== 1'b0)  begin n_fail++; $display("FAIL rst_mem_cs: got %b expected 0", bus.mem_cs); end
      if (bus.c_stall !== 1'b1) begin n_fail++; $display("FAIL rst_c_stall: got %b expected 1", bus.c_stall); end
      @(posedge clk);
    end
    #1;
    n_checks += 3;
    if (bus.c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_c_rvalid: got %b expected 0", bus.c_rvalid); end
    if (bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_d_rvalid: got %b expected 0", bus.d_rvalid); end
    if (bus.rdata !== 32'h0)   begin n_fail++; $display("FAIL rst_rdata: got %h expected 0", bus.rdata); end
    rst = 1'b0;
    #1;
    n_checks += 2;
    if (bus.c_gnt !== 1'b1) begin n_fail++; $display("FAIL rst_first_tie_c: got %b expected 1", bus.c_gnt); end
    if (bus.d_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_first_tie_d: got %b expected 0", bus.d_gnt); end
    $display("test_reset: first tie after reset c_gnt=%b d_gnt=%b", bus.c_gnt, bus.d_gnt);
    tick();
    set_idle();
  endtask

  task automatic test_single_core();
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h10; bus.c_wdata = 32'hDEADBEEF; bus.c_mask = 4'hF;
    #1;
    n_checks += 3;
    if (bus.c_gnt !== 1'b1)        begin n_fail++; $display("FAIL st_c_gnt: got %b expected 1", bus.c_gnt); end
    if (bus.mem_wr_en !== 1'b1)    begin n_fail++; $display("FAIL st_wr_en: got %b expected 1", bus.mem_wr_en); end
    if (bus.mem_addr !== 32'h10)   begin n_fail++; $display("FAIL st_addr: got %h expected 10", bus.mem_addr); end
    $display("test_single_core: store 0x10 <= deadbeef");
    tick();
    bus.c_we = 1'b0;
    n_checks += 1;
    if (bus.c_rvalid !== 1'b0) begin n_fail++; $display("FAIL st_no_rvalid: got %b expected 0", bus.c_rvalid); end
    #1;
    n_checks += 2;
    if (bus.c_gnt !== 1'b1)     begin n_fail++; $display("FAIL ld_c_gnt: got %b expected 1", bus.c_gnt); end
    if (bus.mem_rd_en !== 1'b1) begin n_fail++; $display("FAIL ld_rd_en: got %b expected 1", bus.mem_rd_en); end
    tick();
    set_idle();
    n_checks += 3;
    if (bus.c_rvalid !== 1'b1)       begin n_fail++; $display("FAIL ld_c_rvalid: got %b expected 1", bus.c_rvalid); end
    if (bus.d_rvalid !== 1'b0)       begin n_fail++; $display("FAIL ld_d_rvalid: got %b expected 0", bus.d_rvalid); end
    if (bus.rdata !== 32'hDEADBEEF)  begin n_fail++; $display("FAIL ld_rdata: got %h expected deadbeef", bus.rdata); end
    $display("test_single_core: load 0x10 => %h", bus.rdata);
    // partial-lane store into a word that still holds its initial pattern
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h20; bus.c_wdata = 32'h12345678; bus.c_mask = 4'b0011;
    tick();
    bus.c_we = 1'b0;
    tick();
    set_idle();
    n_checks += 1;
    if (bus.rdata !== 32'hA0005678) begin n_fail++; $display("FAIL mask_rdata: got %h expected a0005678", bus.rdata); end
    $display("test_single_core: masked store/load 0x20 => %h", bus.rdata);
    tick();
    n_checks += 1;
    if (bus.c_rvalid !== 1'b0) begin n_fail++; $display("FAIL rvalid_one_cycle: got %b expected 0", bus.c_rvalid); end
  endtask

  task automatic test_round_robin();
    bus.d_req = 1'b1; bus.d_addr = 32'h80;
    tick();
    bus.c_req = 1'b1; bus.c_addr = 32'h40;
    for (int i = 0; i < 4; i++) begin
      logic exp_c;
      exp_c = (i % 2 == 0);
      #1;
      n_checks += 3;
      if (bus.c_gnt !== exp_c)   begin n_fail++; $display("FAIL rr_c_gnt[%0d]: got %b expected %b", i, bus.c_gnt, exp_c); end
      if (bus.d_gnt !== !exp_c)  begin n_fail++; $display("FAIL rr_d_gnt[%0d]: got %b expected %b", i, bus.d_gnt, !exp_c); end
      if (bus.c_stall !== !exp_c) begin n_fail++; $display("FAIL rr_c_stall[%0d]: got %b expected %b", i, bus.c_stall, !exp_c); end
      $display("test_round_robin: cycle %0d c_gnt=%b d_gnt=%b", i, bus.c_gnt, bus.d_gnt);
      tick();
      n_checks += 3;
      if (bus.c_rvalid !== exp_c)  begin n_fail++; $display("FAIL rr_c_rvalid[%0d]: got %b expected %b", i, bus.c_rvalid, exp_c); end
      if (bus.d_rvalid !== !exp_c) begin n_fail++; $display("FAIL rr_d_rvalid[%0d]: got %b expected %b", i, bus.d_rvalid, !exp_c); end
      if (bus.rdata !== (exp_c ? 32'hA0000010 : 32'hA0000020))
        begin n_fail++; $display("FAIL rr_rdata[%0d]: got %h", i, bus.rdata); end
    end
    set_idle();
  endtask

  task automatic test_burst_lock();
    bus.c_req = 1'b1; bus.c_addr = 32'h40;
    tick();
    bus.d_req = 1'b1; bus.d_addr = 32'h80; bus.d_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic exp_d;
      exp_d = (i % 5 != 4);
      #1;
      n_checks += 3;
      if (bus.d_gnt !== exp_d)   begin n_fail++; $display("FAIL burst_d_gnt[%0d]: got %b expected %b", i, bus.d_gnt, exp_d); end
      if (bus.c_gnt !== !exp_d)  begin n_fail++; $display("FAIL burst_c_gnt[%0d]: got %b expected %b", i, bus.c_gnt, !exp_d); end
      if (bus.c_stall !== exp_d) begin n_fail++; $display("FAIL burst_c_stall[%0d]: got %b expected %b", i, bus.c_stall, exp_d); end
      $display("test_burst_lock: cycle %0d c_gnt=%b d_gnt=%b", i, bus.c_gnt, bus.d_gnt);
      tick();
    end
    set_idle();
  endtask

  task automatic test_lock_core_idle();
    int waited;
    logic got;
    bus.d_req = 1'b1; bus.d_addr = 32'h80; bus.d_lock = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks += 1;
      if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL idle_lock_d_gnt[%0d]: got %b expected 1", i, bus.d_gnt); end
      tick();
    end
    $display("test_lock_core_idle: 10 locked DMA cycles done");
    bus.c_req = 1'b1; bus.c_addr = 32'h40;
    got = 1'b0;
    waited = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      #1;
      if (bus.c_gnt === 1'b1) begin got = 1'b1; waited = k + 1; end
      tick();
    end
    n_checks += 2;
    if (got !== 1'b1) begin n_fail++; $display("FAIL core_after_lock_gnt: got %b expected 1 within 8 cycles", got); end
    if (waited != 5)  begin n_fail++; $display("FAIL core_after_lock_wait: got %0d expected 5", waited); end
    $display("test_lock_core_idle: core granted on cycle %0d", waited);
    set_idle();
  endtask

  task automatic test_reset_mid_access();
    bus.d_req = 1'b1; bus.d_addr = 32'h80; bus.d_lock = 1'b1;
    #1;
    n_checks += 1;
    if (bus.d_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_pre_d_gnt: got %b expected 1", bus.d_gnt); end
    tick();
    rst = 1'b1;
    bus.c_req = 1'b1; bus.c_addr = 32'h40;
    #1;
    n_checks += 3;
    if (bus.d_gnt !== 1'b0)     begin n_fail++; $display("FAIL mid_rst_d_gnt: got %b expected 0", bus.d_gnt); end
    if (bus.mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_rd_en: got %b expected 0", bus.mem_rd_en); end
    if (bus.c_stall !== 1'b1)   begin n_fail++; $display("FAIL mid_rst_c_stall: got %b expected 1", bus.c_stall); end
    tick();
    n_checks += 2;
    if (bus.d_rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_d_rvalid: got %b expected 0", bus.d_rvalid); end
    if (bus.rdata !== 32'h0)   begin n_fail++; $display("FAIL mid_rdata: got %h expected 0", bus.rdata); end
    rst = 1'b0;
    bus.d_lock = 1'b0;
    #1;
    n_checks += 1;
    if (bus.c_gnt !== 1'b1) begin n_fail++; $display("FAIL mid_tie_c_gnt: got %b expected 1", bus.c_gnt); end
    $display("test_reset_mid_access: tie after reset c_gnt=%b d_gnt=%b", bus.c_gnt, bus.d_gnt);
    tick();
    set_idle();
    n_checks += 2;
    if (bus.c_rvalid !== 1'b1)     begin n_fail++; $display("FAIL mid_c_rvalid: got %b expected 1", bus.c_rvalid); end
    if (bus.rdata !== 32'hA0000010) begin n_fail++; $display("FAIL mid_c_rdata: got %h expected a0000010", bus.rdata); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + 32'(i);
    set_idle();
    test_reset();
    test_single_core();
    test_round_robin();
    test_burst_lock();
    test_lock_core_idle();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
